// File: rtl/pdnn_pkg.sv
// Shared constants and state encoding for the parameter loader feeding the
// 24-way parameter distributor of the LVI-PDNN QP solver.
package pdnn_pkg;

    localparam int WORD_W  = 32;
    localparam int ADDR_W  = 7;
    localparam int CNT_W   = 5;
    localparam int N_LINES = 24;

    // Address 0 is the distributor's no-target slot; bubbles land here.
    localparam logic [ADDR_W-1:0] DUMMY_ADDR = '0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CHK   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/param_loader_24_if.sv
// Source stream plus distributor bus for param_loader_24.
//
// Handshake: a word transfers on a rising clk edge where s_valid and s_ready
// are both high. The source holds s_data stable while s_valid is high and
// s_ready is low; s_ready never depends combinationally on s_valid.
//
// Distributor bus: en is active-low; dout lags addr by exactly one cycle.
interface param_loader_24_if;
    import pdnn_pkg::*;

    logic                     s_valid;
    logic                     s_ready;
    logic signed [WORD_W-1:0] s_data;
    logic                     en;
    logic [ADDR_W-1:0]        addr;
    logic signed [WORD_W-1:0] dout;

    // Source / test side
    modport master (
        output s_valid, s_data,
        input  s_ready, en, addr, dout
    );

    // Loader side
    modport slave (
        input  s_valid, s_data,
        output s_ready, en, addr, dout
    );

endinterface

// File: rtl/param_loader_24_skew_pipe.sv
// Two-stage address/data skew pipeline: address leaves one cycle after the
// accept, data one cycle after the address.
module skew_pipe
    import pdnn_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     accept,
    input  logic [ADDR_W-1:0]        addr_in,
    input  logic signed [WORD_W-1:0] data_in,
    output logic [ADDR_W-1:0]        addr,
    output logic signed [WORD_W-1:0] dout
);

    logic signed [WORD_W-1:0] data_q;

    // Stage 1 issues the address (dummy when idle); stage 2 follows with data.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr   <= DUMMY_ADDR;
            data_q <= '0;
            dout   <= '0;
        end else begin
            addr <= accept ? addr_in : DUMMY_ADDR;
            if (accept) begin
                data_q <= data_in;
            end
            dout <= data_q;
        end
    end

endmodule

// File: rtl/param_loader_24.sv
// param_loader_24: accepts N_WORDS parameter words after a start pulse and
// writes word i to distributor address i+1 through the skew pipeline.
// Optional trailing checksum word compiled in with PARAM_LOADER_CHKSUM_EN.
module param_loader_24
    import pdnn_pkg::*;
#(
    parameter int N_WORDS = N_LINES
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    param_loader_24_if.slave    bus,
    output logic                busy,
    output logic                done,
    output logic                err,
    output state_t              state_dbg
);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              drain_q, drain_d;
    logic              accept;
    logic              load_accept;
    logic              last_word;
    logic [ADDR_W-1:0] next_addr;

    assign accept      = bus.s_valid && bus.s_ready;
    assign load_accept = accept && (state_q == ST_LOAD);
    assign last_word   = (cnt_q == CNT_W'(N_WORDS - 1));
    assign next_addr   = ADDR_W'(cnt_q) + ADDR_W'(1);
    assign state_dbg   = state_q;

    // State, word counter and drain-cycle register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            drain_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            drain_q <= drain_d;
        end
    end

    // Next-state logic; the counter saturates on the last word instead of wrapping.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        drain_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    if (last_word) begin
`ifdef PARAM_LOADER_CHKSUM_EN
                        state_d = ST_CHK;
`else
                        state_d = ST_DRAIN;
`endif
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
`ifdef PARAM_LOADER_CHKSUM_EN
            ST_CHK: begin
                if (accept) begin
                    state_d = ST_DRAIN;
                end
            end
`endif
            ST_DRAIN: begin
                drain_d = ~drain_q;
                if (drain_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode straight from the state register.
    always_comb begin
        bus.s_ready = 1'b0;
        bus.en      = 1'b1;
        busy        = (state_q != ST_IDLE);
        done        = (state_q == ST_DONE);
        case (state_q)
            ST_LOAD: begin
                bus.s_ready = 1'b1;
                bus.en      = 1'b0;
            end
            ST_CHK: begin
                bus.s_ready = 1'b1;
                bus.en      = 1'b0;
            end
            ST_DRAIN: begin
                bus.en      = 1'b0;
            end
            default: begin
                bus.s_ready = 1'b0;
                bus.en      = 1'b1;
            end
        endcase
    end

    skew_pipe u_skew_pipe (
        .clk     (clk),
        .rst     (rst),
        .accept  (load_accept),
        .addr_in (next_addr),
        .data_in (bus.s_data),
        .addr    (bus.addr),
        .dout    (bus.dout)
    );

`ifdef PARAM_LOADER_CHKSUM_EN
    logic [WORD_W-1:0] sum_q;
    logic              mism_q;
    logic              err_q;

    // Running sum of payload words; the mismatch becomes visible as err in DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q  <= '0;
            mism_q <= 1'b0;
            err_q  <= 1'b0;
        end else if (state_q == ST_IDLE && start) begin
            sum_q  <= '0;
            mism_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            if (load_accept) begin
                sum_q <= sum_q + $unsigned(bus.s_data);
            end
            if (state_q == ST_CHK && accept) begin
                mism_q <= ($unsigned(bus.s_data) != sum_q);
            end
            if (state_q == ST_DRAIN && drain_q && mism_q) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_param_loader_24.sv
// Scoreboard bench for param_loader_24: the driver pushes the expected
// distributor write for every accepted word; a negedge monitor pops and
// compares addresses, their cycle and the lagging data, and models the
// distributor's line storage.
`timescale 1ns/1ps
module tb_param_loader_24;
    import pdnn_pkg::*;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    logic   start = 1'b0;
    logic   busy, done, err;
    state_t state_dbg;

    param_loader_24_if bus ();

    param_loader_24 #(.N_WORDS(24)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bus       (bus.slave),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .state_dbg (state_dbg)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

`ifdef PARAM_LOADER_CHKSUM_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif
    localparam int BASE_DONE = 27 + EXTRA;
    localparam logic [31:0] GOOD_SUM = 32'h012C_0000;

    int n_tests = 0;
    int n_fail  = 0;

    logic [38:0] exp_q[$];
    int          exp_cyc_q[$];
    logic [31:0] lines [1:24];
    int          start_ref = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    logic        done_busy = 1'b0;
    logic        done_err = 1'b0;

    function automatic logic [31:0] word(input int i);
        return 32'h0001_0000 * (i + 1);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor / scoreboard
    logic        pend = 1'b0;
    logic [31:0] pend_data = '0;
    logic [6:0]  prev_addr = '0;
    always @(negedge clk) begin
        logic [38:0] e;
        int          ec;
        if (rst) begin
            pend      = 1'b0;
            prev_addr = '0;
        end else begin
            if (pend) begin
                check("dout", bus.dout, pend_data);
                pend = 1'b0;
            end
            if (!bus.en && prev_addr >= 1 && prev_addr <= 24)
                lines[prev_addr] = bus.dout;
            prev_addr = bus.addr;
            if (bus.addr != 7'd0) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL addr_unexpected: got %0d expected 0", bus.addr);
                end else begin
                    e  = exp_q.pop_front();
                    ec = exp_cyc_q.pop_front();
                    check("addr", {25'd0, bus.addr}, {25'd0, e[38:32]});
                    check("addr_cycle", cyc - start_ref, ec);
                    pend      = 1'b1;
                    pend_data = e[31:0];
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc  = cyc - start_ref;
                done_busy = busy;
                done_err  = err;
            end
        end
    end

    // Driver: one load; abort_after >= 0 stops (for a reset) after that many words.
    task automatic run_load(input logic [63:0] stall_mask, input logic [63:0] start_mask,
                            input int abort_after, input logic [31:0] chk_word,
                            input int exp_done);
        int   idx = 0;
        int   j;
        int   d0;
        int   total;
        logic hs;
        total = N_LINES + EXTRA;
        for (int k = 1; k <= 24; k++) lines[k] = 32'hDEAD_BEEF;
        d0 = done_cnt;
        @(posedge clk); #1;
        start     = 1'b1;
        start_ref = cyc;
        check("busy_cycle0", busy, 0);
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_cycle1", busy, 1);
        check("err_cleared", err, 0);
        j = 1;
        while (done_cnt == d0 && j < 150) begin
            if (abort_after >= 0 && idx == abort_after) break;
            start       = (j < 64) ? start_mask[j] : 1'b0;
            bus.s_valid = (idx < total) && !((j < 64) && stall_mask[j]);
            bus.s_data  = (idx < N_LINES) ? word(idx) : chk_word;
            hs = bus.s_valid && bus.s_ready;
            @(posedge clk);
            if (hs) begin
                if (idx < N_LINES) begin
                    exp_q.push_back({7'(idx + 1), word(idx)});
                    exp_cyc_q.push_back(j + 1);
                end
                idx++;
            end
            #1;
            j++;
        end
        bus.s_valid = 1'b0;
        start       = 1'b0;
        if (abort_after >= 0) return;
        check("done_seen", done_cnt - d0, 1);
        check("done_cycle", done_cyc, exp_done);
        check("busy_at_done", done_busy, 1);
        check("exp_q_empty", exp_q.size(), 0);
        for (int k = 1; k <= 24; k++)
            check($sformatf("line%0d", k), lines[k], word(k - 1));
        check("done_pulse_end", done, 0);
        check("busy_after_done", busy, 0);
        check("en_idle", bus.en, 1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_en"}, bus.en, 1);
        check({tag, "_addr"}, bus.addr, 0);
        check({tag, "_dout"}, bus.dout, 0);
        check({tag, "_s_ready"}, bus.s_ready, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
    endtask

    initial begin
        logic [63:0] stalls;
        logic [63:0] starts;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (10) @(posedge clk);
        #1 check_reset_vals("reset_idle");

        // Back-to-back full load
        run_load(64'd0, 64'd0, -1, GOOD_SUM, BASE_DONE);

        // Source stalls on cycles 5 and 10-12
        stalls = (64'd1 << 5) | (64'd1 << 10) | (64'd1 << 11) | (64'd1 << 12);
        run_load(stalls, 64'd0, -1, GOOD_SUM, BASE_DONE + 4);

        // Reset after 8 words, then a full reload
        run_load(64'd0, 64'd0, 8, GOOD_SUM, 0);
        rst = 1'b1;
        exp_q.delete();
        exp_cyc_q.delete();
        @(posedge clk); #1;
        check_reset_vals("mid_reset");
        @(posedge clk); #1;
        rst = 1'b0;
        run_load(64'd0, 64'd0, -1, GOOD_SUM, BASE_DONE);

        // start pulses during LOAD and during the drain
        starts = (64'd1 << 6) | (64'd1 << 25) | (64'd1 << 26);
        run_load(64'd0, starts, -1, GOOD_SUM, BASE_DONE);

`ifdef PARAM_LOADER_CHKSUM_EN
        run_load(64'd0, 64'd0, -1, GOOD_SUM, BASE_DONE);
        check("err_good_sum", done_err, 0);
        run_load(64'd0, 64'd0, -1, GOOD_SUM + 32'd1, BASE_DONE);
        check("err_bad_sum", done_err, 1);
        repeat (5) @(posedge clk);
        #1 check("err_sticky_idle", err, 1);
        run_load(64'd0, 64'd0, -1, GOOD_SUM, BASE_DONE);
        check("err_after_good", done_err, 0);
`endif

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Watchdog
    initial begin
        #2_000_000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
